// File: rtl/wptr_full.sv
// wptr_full: write-domain pointer and full/status controller for an
// asynchronous FIFO. Keeps a binary write pointer with a wrap bit, publishes
// its Gray image for the write-to-read synchronizer and derives full,
// almost-full, fill level and sticky overflow from the synchronized Gray read
// pointer. Status is conservative: it can only over-report occupancy, because
// the read pointer it sees is delayed by the synchronizer.
module wptr_full #(
  parameter int ADDRSIZE     = 6,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  // Level at or above which almost-full is reported.
  localparam int                AFULL_INT   = (32'sd1 <<< ADDRSIZE) - AFULL_MARGIN;
  localparam logic [ADDRSIZE:0] AFULL_LEVEL = AFULL_INT[ADDRSIZE:0];

  // Binary to reflected Gray code.
  function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Reflected Gray code to binary: each bit is the XOR of all Gray bits above and including it.
  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDRSIZE:0] wbin;
  logic              accept;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] rptr_full_pattern;
  logic              wfull_next;
  logic [ADDRSIZE:0] wlevel_next;
  logic              walmost_full_next;

  // RAM address comes straight from the current binary pointer so the write
  // in this cycle lands at the address that is about to be consumed.
  assign waddr = wbin[ADDRSIZE-1:0];

  // Next-pointer and status computation against the synchronized read pointer.
  always_comb begin
    accept            = winc & ~wfull;
    wbinnext          = wbin + {{ADDRSIZE{1'b0}}, accept};
    wgraynext         = bin2gray(wbinnext);
    rbin              = gray2bin(wq2_rptr);
    // Full when the write pointer has lapped the read pointer once: in Gray
    // code that means the top two bits are inverted and the rest are equal.
    rptr_full_pattern = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    wfull_next        = (wgraynext == rptr_full_pattern);
    wlevel_next       = wbinnext - rbin;
    walmost_full_next = (wlevel_next >= AFULL_LEVEL);
  end

  // Pointer, flag and level registers all advance together on every edge.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin         <= {(ADDRSIZE+1){1'b0}};
      wptr         <= {(ADDRSIZE+1){1'b0}};
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= {(ADDRSIZE+1){1'b0}};
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wfull        <= wfull_next;
      walmost_full <= walmost_full_next;
      wlevel       <= wlevel_next;
      woverflow    <= woverflow | (winc & wfull);
    end
  end

endmodule

// File: tb/tb_wptr_full.sv
// Bench for wptr_full: two instances (ADDRSIZE=6/AFULL_MARGIN=4 and
// ADDRSIZE=3/AFULL_MARGIN=1) driven with the same write requests. A counting
// model (total writes accepted vs. total reads observed) predicts every
// output; predictions are queued by the driver and consumed by a monitor.
module tb_wptr_full;

  logic       wclk = 1'b0;
  logic       wrst = 1'b1;
  logic       winc = 1'b0;
  logic [6:0] rptr0 = 7'd0;
  logic [3:0] rptr1 = 4'd0;

  logic [5:0] waddr0;
  logic [6:0] wptr0;
  logic [6:0] wlevel0;
  logic       wfull0, waf0, wovf0;
  logic [2:0] waddr1;
  logic [3:0] wptr1;
  logic [3:0] wlevel1;
  logic       wfull1, waf1, wovf1;

  wptr_full #(.ADDRSIZE(6), .AFULL_MARGIN(4)) dut0 (
    .wclk(wclk), .wrst(wrst), .winc(winc), .wq2_rptr(rptr0),
    .waddr(waddr0), .wptr(wptr0), .wfull(wfull0), .walmost_full(waf0),
    .wlevel(wlevel0), .woverflow(wovf0)
  );

  wptr_full #(.ADDRSIZE(3), .AFULL_MARGIN(1)) dut1 (
    .wclk(wclk), .wrst(wrst), .winc(winc), .wq2_rptr(rptr1),
    .waddr(waddr1), .wptr(wptr1), .wfull(wfull1), .walmost_full(waf1),
    .wlevel(wlevel1), .woverflow(wovf1)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    int waddr;
    int wptr;
    int wlevel;
    bit full;
    bit af;
    bit ovf;
    bit hchk;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int total = 0;
  int bad   = 0;

  // Model state per instance: counts are unbounded integers.
  int wcnt[2];
  int rcnt[2];
  bit mfull[2];
  bit movf[2];

  function automatic int depth_of(input int d);
    return (d == 0) ? 64 : 8;
  endfunction

  function automatic int margin_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // rmode 0: read count = rval; 1: read count trails the post-write count by rval;
  // 2: random advance. Reads never pass data not yet written and never go back.
  task automatic model_step(input int d, input bit w, input int rmode, input int rval,
                            output exp_t e, output int rg);
    int dep;
    int acc;
    int rc;
    int lvl;
    dep = depth_of(d);
    acc = (w && !mfull[d]) ? 1 : 0;
    case (rmode)
      0:       rc = rval;
      1:       rc = wcnt[d] + acc - rval;
      default: rc = rcnt[d] + (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : 0);
    endcase
    if (rc > wcnt[d]) rc = wcnt[d];
    if (rc < rcnt[d]) rc = rcnt[d];
    if (w && mfull[d]) movf[d] = 1'b1;
    wcnt[d] += acc;
    rcnt[d]  = rc;
    lvl      = wcnt[d] - rc;
    mfull[d] = (lvl == dep);
    e.waddr  = wcnt[d] % dep;
    e.wptr   = gray(wcnt[d] % (2 * dep));
    e.wlevel = lvl;
    e.full   = mfull[d];
    e.af     = (lvl >= dep - margin_of(d));
    e.ovf    = movf[d];
    e.hchk   = 1'b1;
    rg       = gray(rc % (2 * dep));
  endtask

  task automatic step(input bit w, input int rmode, input int rval);
    exp_t e0, e1;
    int   g0, g1;
    @(posedge wclk);
    #2;
    wrst = 1'b0;
    model_step(0, w, rmode, rval, e0, g0);
    model_step(1, w, rmode, rval, e1, g1);
    winc  = w;
    rptr0 = g0[6:0];
    rptr1 = g1[3:0];
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  // Reset raised between edges with a write presented; outputs must clear at once.
  task automatic async_reset();
    exp_t e;
    @(posedge wclk);
    #2;
    winc = 1'b1;
    #2;
    wrst = 1'b1;
    #1;
    chk("rst_waddr0",  32'(waddr0),  32'd0);
    chk("rst_wptr0",   32'(wptr0),   32'd0);
    chk("rst_wlevel0", 32'(wlevel0), 32'd0);
    chk("rst_flags0",  32'({wfull0, waf0, wovf0}), 32'd0);
    chk("rst_waddr1",  32'(waddr1),  32'd0);
    chk("rst_wptr1",   32'(wptr1),   32'd0);
    chk("rst_flags1",  32'({wfull1, waf1, wovf1}), 32'd0);
    for (int d = 0; d < 2; d++) begin
      wcnt[d] = 0; rcnt[d] = 0; mfull[d] = 1'b0; movf[d] = 1'b0;
    end
    rptr0 = 7'd0;
    rptr1 = 4'd0;
    e = '{default: 0};
    q0.push_back(e);
    q1.push_back(e);
  endtask

  // Monitor: after each edge, compare the outputs with the oldest prediction.
  initial begin
    exp_t       e;
    logic [6:0] p0;
    logic [3:0] p1;
    p0 = 7'd0;
    p1 = 4'd0;
    forever begin
      @(posedge wclk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("waddr0",  32'(waddr0),  32'(e.waddr));
        chk("wptr0",   32'(wptr0),   32'(e.wptr));
        chk("wlevel0", 32'(wlevel0), 32'(e.wlevel));
        chk("wfull0",  32'(wfull0),  32'(e.full));
        chk("wafull0", 32'(waf0),    32'(e.af));
        chk("wovf0",   32'(wovf0),   32'(e.ovf));
        if (e.hchk) chk("gray_step0", 32'($countones(wptr0 ^ p0) <= 1), 32'd1);
        p0 = wptr0;
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("waddr1",  32'(waddr1),  32'(e.waddr));
        chk("wptr1",   32'(wptr1),   32'(e.wptr));
        chk("wlevel1", 32'(wlevel1), 32'(e.wlevel));
        chk("wfull1",  32'(wfull1),  32'(e.full));
        chk("wafull1", 32'(waf1),    32'(e.af));
        chk("wovf1",   32'(wovf1),   32'(e.ovf));
        if (e.hchk) chk("gray_step1", 32'($countones(wptr1 ^ p1) <= 1), 32'd1);
        p1 = wptr1;
      end
    end
  end

  initial begin
    int waited;
    for (int d = 0; d < 2; d++) begin
      wcnt[d] = 0; rcnt[d] = 0; mfull[d] = 1'b0; movf[d] = 1'b0;
    end
    #3;
    chk("init_wptr0",   32'(wptr0),   32'd0);
    chk("init_wlevel0", 32'(wlevel0), 32'd0);
    chk("init_flags0",  32'({wfull0, waf0, wovf0}), 32'd0);
    chk("init_flags1",  32'({wfull1, waf1, wovf1}), 32'd0);

    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    // Fill with the read pointer parked at zero, then overrun three times.
    for (int i = 0; i < 64; i++) step(1'b1, 0, 0);
    for (int i = 0; i < 3; i++)  step(1'b1, 0, 0);
    // One read becomes visible: full drops, level 63.
    step(1'b0, 0, 1);
    step(1'b0, 0, 1);

    // Streaming with the reader three entries behind, through the pointer wrap.
    async_reset();
    for (int i = 0; i < 200; i++) step(1'b1, 1, 3);
    // Reader stalls; climb to level 40 and reset between edges.
    for (int i = 0; i < 37; i++) step(1'b1, 1, 100000);
    async_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) step($urandom_range(0, 3) != 0, 2, 0);
    step(1'b0, 1, 100000);

    waited = 0;
    while ((q0.size() > 0 || q1.size() > 0) && waited < 20) begin
      @(posedge wclk);
      waited++;
    end
    #2;
    chk("queue_drained", 32'(q0.size() + q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wptr_full.md
# wptr_full

Write-side pointer and full-flag controller for the asynchronous FIFO, in the write clock domain. It consumes the Gray-coded read pointer already synchronized into the write domain. From that pointer and the write request it produces:
- the binary write address for the dual-port RAM;
- the Gray-coded write pointer for the write-to-read synchronizer;
- the full, almost-full, fill-level and overflow status outputs.

## Interface
- ADDRSIZE, 6, RAM address width; FIFO depth = 2^ADDRSIZE
- AFULL_MARGIN, 4, walmost_full asserts when free entries <= AFULL_MARGIN (legal range 1 .. 2^ADDRSIZE-1)

- wclk  input  1  write clock; all state on rising edge
- wrst  input  1  asynchronous, active-high reset
- winc  input  1  write request; accepted only when wfull=0
- wq2_rptr  input  ADDRSIZE+1  Gray read pointer, already synchronized to wclk
- waddr  output  ADDRSIZE  RAM write address (low ADDRSIZE bits of binary write pointer)
- wptr  output  ADDRSIZE+1  registered Gray write pointer, to the write-to-read synchronizer
- wfull  output  1  FIFO full, registered
- walmost_full  output  1  free entries <= AFULL_MARGIN, registered
- wlevel  output  ADDRSIZE+1  occupied entries as seen from the write domain, registered, range 0..2^ADDRSIZE
- woverflow  output  1  sticky: set by a write attempt while full

## Operation
- State: binary pointer wbin [ADDRSIZE:0], Gray pointer wptr, wfull, walmost_full, wlevel, woverflow.
- Accepted write: winc & ~wfull.
- wbinnext = wbin + accepted write, modulo 2^(ADDRSIZE+1). The extra MSB is the wrap bit.
- wgraynext = (wbinnext >> 1) ^ wbinnext.
- waddr = wbin[ADDRSIZE-1:0], combinational from the register, so the RAM write uses the current address.
- Full compare: wfull_next = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
- Read pointer to binary: rbin[ADDRSIZE] = wq2_rptr[ADDRSIZE]; rbin[i] = rbin[i+1] ^ wq2_rptr[i] for i descending.
- wlevel_next = wbinnext - rbin, modulo 2^(ADDRSIZE+1). Must equal 2^ADDRSIZE exactly when wfull_next=1.
- walmost_full_next = (wlevel_next >= 2^ADDRSIZE - AFULL_MARGIN).
- woverflow: set on any cycle with winc & wfull. Cleared only by reset.
- No FSM. Pointer, flag and level registers update together every cycle.
- Status is pessimistic by design, because the read pointer arrives with a 2-wclk synchronizer delay:
  - wfull and walmost_full may stay asserted after reads have freed space;
  - wlevel may over-report occupancy;
  - none of these outputs may ever under-report.

## Timing
- Reset (wrst high, asynchronous): wbin=0, wptr=0, waddr=0, wfull=0, walmost_full=0, wlevel=0, woverflow=0. Outputs change without waiting for a wclk edge.
- Reset release: the first rising edge after wrst falls may accept a write.
- Write latency: a write accepted at edge N updates waddr, wptr, wlevel and flags at edge N.
- Flag timing:
  - wfull rises on the same edge as the write that fills the last entry;
  - with winc held high, the next edge is blocked;
  - wfull falls on the first edge at which the new wq2_rptr value is sampled.
- Write while full: wbin, wptr and wlevel unchanged; woverflow=1 from that edge on.
- Simultaneous read-pointer advance and write when level = depth-1: the write is accepted, then wfull_next is evaluated against the new wq2_rptr.
- Wrap-around: wbin rolls from 2^(ADDRSIZE+1)-1 to 0. wptr Gray code changes exactly one bit per accepted write, including at the wrap.
- Reset mid-operation: all state returns to reset values immediately. Any write presented in the reset cycle is dropped.

## Test plan
- Reset, then 64 writes with wq2_rptr=0 → waddr steps 0..63, wptr=7'h60 and wfull=1 after the 64th write, wlevel=64, woverflow=0.
- Fill to 60 writes with wq2_rptr=0 → walmost_full=0 after write 59 and 1 after write 60, wlevel=60.
- Full, then 3 extra winc cycles → wptr holds 7'h60, wlevel holds 64, woverflow=1 and stays 1; set wq2_rptr=7'h01 → wfull=0 at next edge, wlevel=63.
- Stream 200 writes with wq2_rptr tracking the write pointer 3 entries behind → wptr Hamming distance 1 per accepted write, clean wrap 7'h40→7'h00 on binary pointer roll, wfull never asserts, wlevel=3 at steady state.
- Assert wrst asynchronously between edges at wlevel=40 → all outputs 0 before the next wclk edge; first write after release goes to waddr=0.
- Run the same level and flag checks with ADDRSIZE=3, AFULL_MARGIN=1 → wfull after 8 writes (wptr=4'hC), walmost_full after 7.
